// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 single-precision constants and the FSM state type
// for fp_dot_accumulator and mac_unit. No ports.
package fp_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [FP_W-1:0]  FP_ZERO  = 32'h0000_0000;
  localparam logic [FP_W-1:0]  FP_QNAN  = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_ONES = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mac_unit.sv
// mac_unit: combinational fused single-precision y = a*b + acc, RNE, denormals flushed.
// Ports: a_i, b_i, acc_i (32b operands) -> y_o (32b result).
module mac_unit
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  input  logic [FP_W-1:0] acc_i,
  output logic [FP_W-1:0] y_o
);

  // Right shift that folds every lost bit into the LSB (sticky).
  function automatic logic [51:0] shr_st(
    input logic [51:0] v,
    input logic [11:0] d
  );
    logic [51:0] m;
    if (d >= 12'd52) begin
      shr_st = {51'b0, |v};
    end else begin
      m      = (52'b1 << d) - 52'b1;
      shr_st = (v >> d) | {51'b0, |(v & m)};
    end
  endfunction

  logic              sa, sb, sc, sp, s;
  logic [EXP_W-1:0]  ea, eb, ec;
  logic [MAN_W-1:0]  fa, fb, fc;
  logic              a_nan, b_nan, c_nan;
  logic              a_inf, b_inf, c_inf;
  logic              a_zero, b_zero, c_zero;
  logic              p_inf, p_zero;
  logic [47:0]       mp, mc;
  logic signed [11:0] xp, xc, x, e;
  logic [11:0]       d, lz;
  logic [51:0]       pa, ca, r, n;
  logic [23:0]       man;
  logic [24:0]       man_r;
  logic [MAN_W-1:0]  frac;
  logic              rnd;
  logic [FP_W-1:0]   fin;

  always_comb begin
    {sa, ea, fa} = a_i;
    {sb, eb, fb} = b_i;
    {sc, ec, fc} = acc_i;
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    c_zero = (ec == '0);
    a_inf  = (ea == EXP_ONES) && (fa == '0);
    b_inf  = (eb == EXP_ONES) && (fb == '0);
    c_inf  = (ec == EXP_ONES) && (fc == '0);
    a_nan  = (ea == EXP_ONES) && (fa != '0);
    b_nan  = (eb == EXP_ONES) && (fb != '0);
    c_nan  = (ec == EXP_ONES) && (fc != '0);
    sp     = sa ^ sb;
    p_inf  = a_inf | b_inf;
    p_zero = a_zero | b_zero;

    // Both significands carry LSB weight 2^(x-127-46).
    mp = {24'b0, 1'b1, fa} * {24'b0, 1'b1, fb};
    xp = $signed({4'b0, ea}) + $signed({4'b0, eb}) - 12'sd127;
    mc = c_zero ? 48'b0 : {1'b0, 1'b1, fc, 23'b0};
    xc = c_zero ? xp : $signed({4'b0, ec});

    pa = {1'b0, mp, 3'b0};
    ca = {1'b0, mc, 3'b0};
    if (xp >= xc) begin
      x  = xp;
      d  = 12'(xp - xc);
      ca = shr_st(ca, d);
    end else begin
      x  = xc;
      d  = 12'(xc - xp);
      pa = shr_st(pa, d);
    end

    if (sp == sc) begin
      r = pa + ca;
      s = sp;
    end else if (pa >= ca) begin
      r = pa - ca;
      s = sp;
    end else begin
      r = ca - pa;
      s = sc;
    end

    lz = 12'd0;
    for (int i = 0; i < 52; i++) begin
      if (r[i]) lz = 12'(i);
    end
    n     = r << (12'd51 - lz);
    man   = n[51:28];
    rnd   = n[27] & ((|n[26:0]) | man[0]);
    man_r = {1'b0, man} + {24'b0, rnd};
    e     = x + $signed(lz) - 12'sd49;
    if (man_r[24]) begin
      e    = e + 12'sd1;
      frac = man_r[23:1];
    end else begin
      frac = man_r[22:0];
    end

    if (r == '0)
      fin = FP_ZERO;
    else if (e >= 12'sd255)
      fin = {s, EXP_ONES, {MAN_W{1'b0}}};
    else if (e <= 12'sd0)
      fin = {s, {(FP_W-1){1'b0}}};
    else
      fin = {s, e[EXP_W-1:0], frac};

    if (a_nan | b_nan | c_nan | (p_inf & p_zero)
        | (p_inf & c_inf & (sp != sc)))
      y_o = FP_QNAN;
    else if (p_inf)
      y_o = {sp, EXP_ONES, {MAN_W{1'b0}}};
    else if (c_inf)
      y_o = acc_i;
    else if (p_zero)
      y_o = c_zero ? {sp & sc, {(FP_W-1){1'b0}}} : acc_i;
    else
      y_o = fin;
  end

endmodule

// File: rtl/fp_dot_accumulator.sv
// fp_dot_accumulator: streams a/b pairs through mac_unit into acc_q, emits dot product.
// Ports: start, in_valid/in_ready/in_a/in_b/in_last, out_valid/out_ready/out_data/out_count,
// busy; optional out_special when FP_DOT_SPECIAL_DETECT_EN is defined.
module fp_dot_accumulator
  import fp_pkg::*;
#(
  parameter int VEC_LEN = 8,
  parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_a,
  input  logic [FP_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
`ifdef FP_DOT_SPECIAL_DETECT_EN
  ,
  output logic             out_special
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

  state_t           state_q;
  logic [FP_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q, out_valid_q;
  logic             beat;

  mac_unit u_mac (
    .a_i   (in_a),
    .b_i   (in_b),
    .acc_i (acc_q),
    .y_o   (acc_d)
  );

  assign beat = in_valid && in_ready_q;

`ifdef FP_DOT_SPECIAL_DETECT_EN
  logic spec_q, spec_hit;
  assign spec_hit = (in_a[30:23] == EXP_ONES)
                  | (in_b[30:23] == EXP_ONES)
                  | (acc_d[30:23] == EXP_ONES);
  assign out_special = spec_q;

  always_ff @(posedge clk) begin
    if (rst)
      spec_q <= 1'b0;
    else if (state_q == IDLE && start)
      spec_q <= 1'b0;
    else if (state_q == ACCUM && beat)
      spec_q <= spec_q | spec_hit;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= FP_ZERO;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_q      <= FP_ZERO;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            // Hitting VEC_LEN closes the vector even without in_last.
            if (in_last || cnt_q == CNT_LAST) begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_count = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp_dot_accumulator.sv
// tb_fp_dot_accumulator: directed self-checking bench for fp_dot_accumulator (VEC_LEN=4).
// Also exercises out_special when FP_DOT_SPECIAL_DETECT_EN is defined.
module tb_fp_dot_accumulator;

  localparam int VL = 4;
  localparam int CW = $clog2(VL + 1);

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_last, out_ready;
  logic          in_ready, out_valid, busy;
  logic [31:0]   in_a, in_b, out_data;
  logic [CW-1:0] out_count;
`ifdef FP_DOT_SPECIAL_DETECT_EN
  logic          out_special;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] F1 = 32'h3F800000;
  localparam logic [31:0] F2 = 32'h40000000;
  localparam logic [31:0] F3 = 32'h40400000;
  localparam logic [31:0] F4 = 32'h40800000;
  localparam logic [31:0] F5 = 32'h40A00000;
  localparam logic [31:0] F6 = 32'h40C00000;
  localparam logic [31:0] F7 = 32'h40E00000;
  localparam logic [31:0] F8 = 32'h41000000;

  logic [31:0] va [4];
  logic [31:0] vb [4];

  always #5 clk = ~clk;

  fp_dot_accumulator #(.VEC_LEN(VL)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .busy      (busy)
`ifdef FP_DOT_SPECIAL_DETECT_EN
    ,
    .out_special (out_special)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b,
                      input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      failures++; $display("FAIL reset_out_data got=%h exp=0", out_data);
    end
    checks++;
    if (out_count !== '0) begin
      failures++; $display("FAIL reset_out_count got=%0d exp=0", out_count);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_full_vector();
    out_ready = 1'b1;
    do_start();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL full_open got=%b%b exp=11", in_ready, busy);
    end
    beat(F1, F2, 1'b0);
    beat(F3, F4, 1'b0);
    beat(F5, F6, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL full_early_valid got=%b exp=0", out_valid);
    end
    beat(F7, F8, 1'b0);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL full_valid got=%b exp=1", out_valid);
    end
    checks++;
    if (out_data !== 32'h42C80000) begin
      failures++; $display("FAIL full_data got=%h exp=42c80000", out_data);
    end
    checks++;
    if (out_count !== CW'(4)) begin
      failures++; $display("FAIL full_count got=%0d exp=4", out_count);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL full_ready_done got=%b exp=0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL full_pulse got=%b%b exp=00", out_valid, busy);
    end
  endtask

  task automatic test_in_last();
    out_ready = 1'b1;
    do_start();
    beat(F1, F2, 1'b0);
    beat(F3, F4, 1'b0);
    beat(F5, F6, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL last_valid got=%b exp=1", out_valid);
    end
    checks++;
    if (out_data !== 32'h42300000) begin
      failures++; $display("FAIL last_data got=%h exp=42300000", out_data);
    end
    checks++;
    if (out_count !== CW'(3)) begin
      failures++; $display("FAIL last_count got=%0d exp=3", out_count);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL last_clear got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_gaps();
    out_ready = 1'b1;
    do_start();
    for (int i = 0; i < 4; i++) begin
      beat(va[i], vb[i], 1'b0);
      if (i < 3) begin
        in_a = 32'h7F800000;
        in_b = 32'h7F800000;
        tick();
        tick();
        checks++;
        if (out_count !== CW'(i + 1)) begin
          failures++;
          $display("FAIL gap_count_%0d got=%0d exp=%0d", i, out_count, i + 1);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL gap_valid got=%b exp=1", out_valid);
    end
    checks++;
    if (out_data !== 32'h42C80000) begin
      failures++; $display("FAIL gap_data got=%h exp=42c80000", out_data);
    end
    checks++;
    if (out_count !== CW'(4)) begin
      failures++; $display("FAIL gap_count got=%0d exp=4", out_count);
    end
    tick();
  endtask

  task automatic test_back_to_back_backpressure();
    out_ready = 1'b0;
    do_start();
    for (int i = 0; i < 4; i++) beat(va[i], vb[i], 1'b0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hs_%0d got=%b%b exp=10", k, out_valid, in_ready);
      end
      checks++;
      if (out_data !== 32'h42C80000) begin
        failures++; $display("FAIL bp_data_%0d got=%h exp=42c80000", k, out_data);
      end
      checks++;
      if (out_count !== CW'(4)) begin
        failures++; $display("FAIL bp_count_%0d got=%0d exp=4", k, out_count);
      end
      start = (k == 2);
      tick();
      start = 1'b0;
    end
    checks++;
    if (out_data !== 32'h42C80000 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold got=%h/%b exp=42c80000/1", out_data, out_valid);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got=%b%b%b exp=000", out_valid, busy, in_ready);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL bp_start_ignored got=%b exp=0", busy);
    end
  endtask

  task automatic test_rst_abort();
    out_ready = 1'b1;
    do_start();
    beat(F1, F2, 1'b0);
    beat(F3, F4, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_ctrl got=%b%b%b exp=000", in_ready, busy, out_valid);
    end
    checks++;
    if (out_count !== '0) begin
      failures++; $display("FAIL abort_count got=%0d exp=0", out_count);
    end
    checks++;
    if (out_data !== 32'h0) begin
      failures++; $display("FAIL abort_data got=%h exp=0", out_data);
    end
    do_start();
    beat(F2, F2, 1'b1);
    checks++;
    if (out_data !== 32'h40800000) begin
      failures++; $display("FAIL fresh_data got=%h exp=40800000", out_data);
    end
    checks++;
    if (out_count !== CW'(1) || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL fresh_count got=%0d/%b exp=1/1", out_count, out_valid);
    end
    tick();
  endtask

`ifdef FP_DOT_SPECIAL_DETECT_EN
  task automatic test_special();
    out_ready = 1'b1;
    do_start();
    beat(32'h7FC00000, F1, 1'b1);
    checks++;
    if (out_special !== 1'b1) begin
      failures++; $display("FAIL special_set got=%b exp=1", out_special);
    end
    checks++;
    if (out_data !== 32'h7FC00000) begin
      failures++; $display("FAIL special_nan got=%h exp=7fc00000", out_data);
    end
    tick();
    do_start();
    beat(F1, F1, 1'b1);
    checks++;
    if (out_special !== 1'b0) begin
      failures++; $display("FAIL special_clear got=%b exp=0", out_special);
    end
    checks++;
    if (out_data !== 32'h3F800000) begin
      failures++; $display("FAIL special_data got=%h exp=3f800000", out_data);
    end
    tick();
  endtask
`endif

  initial begin
    va = '{F1, F3, F5, F7};
    vb = '{F2, F4, F6, F8};
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    test_reset();
    test_full_vector();
    test_in_last();
    test_gaps();
    test_back_to_back_backpressure();
    test_rst_abort();
`ifdef FP_DOT_SPECIAL_DETECT_EN
    test_special();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
